oled_i2c_sequencer: RTL and testbench
=====================================

OLED_I2C_SEQUENCER -- requirements
Module: oled_i2c_sequencer

Interface
REQ-001 Parameter: I2C_ADDR, default 7'h3C, 7-bit slave address of the SSD1306 OLED.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse: run the init transaction, then one full-frame refresh.
REQ-005 refresh  input  1  single-cycle pulse: run a full-frame refresh only; valid only once init is complete.
REQ-006 fb_addr  output  10  framebuffer read address, {page[2:0], col[6:0]}.
REQ-007 fb_data  input  8  framebuffer read data, valid exactly 1 cycle after fb_addr.
REQ-008 newd  output  1  one-cycle transaction request to the I2C master.
REQ-009 op  output  1  I2C read/write bit; tied to 0 (write).
REQ-010 waddr  output  7  slave address; equals I2C_ADDR.
REQ-011 din  output  8  current byte offered to the I2C master.
REQ-012 num_byte_send  output  5  byte count of the current transaction, including the control byte.
REQ-013 busy, done, ack_err, done_write  input  1 each  I2C master status: busy level, 1-cycle end-of-transaction pulse, NACK flag, per-byte-sent flag.
REQ-014 ready  output  1  high when in IDLE and able to accept start/refresh.
REQ-015 inited  output  1  sticky; set when the init transaction completes without NACK.
REQ-016 frame_done  output  1  one-cycle pulse when the last chunk of a frame completes.
REQ-017 err  output  1  sticky NACK-abort flag; cleared by rst or start.

Function
REQ-018 States: IDLE, INIT_REQ, INIT_WAIT, PCMD_REQ, PCMD_WAIT, DATA_REQ, DATA_WAIT.
REQ-019 Every *_REQ state behaves as follows:
- Waits for busy==0.
- Loads din with byte 0 of the transaction and sets num_byte_send.
- Pulses newd for exactly 1 cycle.
- Moves to the matching *_WAIT state.
REQ-020 Every *_WAIT state holds until done==1.
- If ack_err==1 on that same cycle: set err, return to IDLE, frame_done is not pulsed.
- Otherwise: advance to the next transaction.
REQ-021 Byte advance:
- On each rising edge of done_write (0->1), step the byte index and drive the next byte on din.
- din must be stable no later than 2 cycles after the done_write rising edge.
- din holds until the next done_write rising edge.
REQ-022 Init transaction: num_byte_send=26.
- Bytes: 00, AE, D5, 80, A8, 3F, D3, 00, 40, 8D, 14, 20, 02, A1, C8, DA, 12, 81, CF, D9, F1, DB, 40, A4, A6, AF (hex).
- On success, set inited and go to PCMD_REQ with page=0.
REQ-023 Page command transaction: num_byte_send=4.
- Bytes: 00, B0|page, 00, 10.
- On success, go to DATA_REQ with chunk=0.
REQ-024 Data chunk transaction: num_byte_send=17.
- Bytes: 40, then 16 bytes of fb_data for col = chunk*16 .. chunk*16+15.
- fb_addr is issued 1 cycle before each data byte is needed; the first framebuffer read is issued during DATA_REQ.
REQ-025 Chunk sequencing:
- chunk 0..7 within a page, then page 0..7.
- After a successful chunk 7 of page 7: pulse frame_done and return to IDLE.
- Otherwise: next chunk, or PCMD_REQ for page+1.
- One frame = 72 transactions, 1024 framebuffer reads.
REQ-026 In IDLE:
- start: clear err, clear inited, go to INIT_REQ.
- refresh with inited==1: go to PCMD_REQ with page=0.
- refresh with inited==0: ignored.
- start and refresh on the same cycle: start wins.
REQ-027 start and refresh are ignored outside IDLE; no queuing.
REQ-028 page, chunk and byte counters do not wrap within a frame; all are cleared on entry to INIT_REQ and PCMD_REQ(page 0).

Reset
REQ-029 While rst is asserted, and until the first clk edge after deassertion:
- state = IDLE.
- newd=0, din=00, num_byte_send=0, fb_addr=0, frame_done=0, err=0, inited=0, ready=1.
- op=0 and waddr=I2C_ADDR at all times.
REQ-030 rst asserted mid-transaction aborts immediately; no further newd until a new start.

Verification
REQ-031 Bench uses a behavioural I2C master model (clk_count4=8), ACK by default, and a framebuffer model with fb[a]=a[7:0]^{5'b0,a[9:7]}.
REQ-032 Init: start -> 1 newd with num_byte_send=26; the 26 din values captured at done_write edges match REQ-022 in order; inited=1.
REQ-033 Page command: after init -> first PCMD transaction bytes 00,B0,00,10; page 5 bytes 00,B5,00,10.
REQ-034 Data: page 2, chunk 3 -> bytes 40, then fb[0x130..0x13F] in order; exactly 72 newd pulses per frame; frame_done pulses once, after the 72nd done.
REQ-035 NACK: ack_err=1 at done of page 3, chunk 0 -> err=1, state IDLE, no frame_done, no further newd; the next start clears err.
REQ-036 Guards:
- refresh before init -> no newd.
- refresh or start while busy -> ignored.
- rst asserted during DATA_WAIT -> all outputs return to REQ-029 values asynchronously.

Source files
------------

// File: rtl/oled_i2c_sequencer.sv
// SSD1306 OLED sequencer: feeds an I2C master the power-up init string and then
// full-frame refreshes read from an external framebuffer, one transaction at a time.
module oled_i2c_sequencer #(
    parameter logic [6:0] I2C_ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       refresh,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       newd,
    output logic       op,
    output logic [6:0] waddr,
    output logic [7:0] din,
    output logic [4:0] num_byte_send,
    input  logic       busy,
    input  logic       done,
    input  logic       ack_err,
    input  logic       done_write,
    output logic       ready,
    output logic       inited,
    output logic       frame_done,
    output logic       err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INIT_REQ  = 3'd1;
    localparam logic [2:0] INIT_WAIT = 3'd2;
    localparam logic [2:0] PCMD_REQ  = 3'd3;
    localparam logic [2:0] PCMD_WAIT = 3'd4;
    localparam logic [2:0] DATA_REQ  = 3'd5;
    localparam logic [2:0] DATA_WAIT = 3'd6;

    logic [2:0] state;
    logic [2:0] page;
    logic [2:0] chunk;
    logic [4:0] byte_idx;
    logic       done_write_q;
    logic       dw_rise;

    // Control byte 0x00 followed by the SSD1306 power-up command string.
    function automatic logic [7:0] init_byte(input logic [4:0] idx);
        case (idx)
            5'd0:  return 8'h00;  5'd1:  return 8'hAE;  5'd2:  return 8'hD5;
            5'd3:  return 8'h80;  5'd4:  return 8'hA8;  5'd5:  return 8'h3F;
            5'd6:  return 8'hD3;  5'd7:  return 8'h00;  5'd8:  return 8'h40;
            5'd9:  return 8'h8D;  5'd10: return 8'h14;  5'd11: return 8'h20;
            5'd12: return 8'h02;  5'd13: return 8'hA1;  5'd14: return 8'hC8;
            5'd15: return 8'hDA;  5'd16: return 8'h12;  5'd17: return 8'h81;
            5'd18: return 8'hCF;  5'd19: return 8'hD9;  5'd20: return 8'hF1;
            5'd21: return 8'hDB;  5'd22: return 8'h40;  5'd23: return 8'hA4;
            5'd24: return 8'hA6;  5'd25: return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] pcmd_byte(input logic [1:0] idx, input logic [2:0] pg);
        case (idx)
            2'd1:    return {5'b10110, pg};
            2'd3:    return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    assign op      = 1'b0;
    assign waddr   = I2C_ADDR;
    assign ready   = (state == IDLE);
    assign dw_rise = done_write & ~done_write_q;

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see pre-edge values; blocking assignment would make results order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            page          <= 3'd0;
            chunk         <= 3'd0;
            byte_idx      <= 5'd0;
            done_write_q  <= 1'b0;
            newd          <= 1'b0;
            din           <= 8'h00;
            num_byte_send <= 5'd0;
            fb_addr       <= 10'd0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
            inited        <= 1'b0;
        end else begin
            newd         <= 1'b0;
            frame_done   <= 1'b0;
            done_write_q <= done_write;
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        inited   <= 1'b0;
                        page     <= 3'd0;
                        chunk    <= 3'd0;
                        byte_idx <= 5'd0;
                        state    <= INIT_REQ;
                    end else if (refresh && inited) begin
                        page     <= 3'd0;
                        chunk    <= 3'd0;
                        byte_idx <= 5'd0;
                        state    <= PCMD_REQ;
                    end
                end
                INIT_REQ: if (!busy) begin
                    din           <= init_byte(5'd0);
                    num_byte_send <= 5'd26;
                    newd          <= 1'b1;
                    byte_idx      <= 5'd0;
                    state         <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (done) begin
                        if (ack_err) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            inited <= 1'b1;
                            page   <= 3'd0;
                            chunk  <= 3'd0;
                            state  <= PCMD_REQ;
                        end
                    end else if (dw_rise && byte_idx != 5'd25) begin
                        byte_idx <= byte_idx + 5'd1;
                        din      <= init_byte(byte_idx + 5'd1);
                    end
                end
                PCMD_REQ: if (!busy) begin
                    din           <= 8'h00;
                    num_byte_send <= 5'd4;
                    newd          <= 1'b1;
                    byte_idx      <= 5'd0;
                    state         <= PCMD_WAIT;
                end
                PCMD_WAIT: begin
                    if (done) begin
                        if (ack_err) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            chunk   <= 3'd0;
                            fb_addr <= {page, 3'd0, 4'd0};
                            state   <= DATA_REQ;
                        end
                    end else if (dw_rise && byte_idx != 5'd3) begin
                        byte_idx <= byte_idx + 5'd1;
                        din      <= pcmd_byte(byte_idx[1:0] + 2'd1, page);
                    end
                end
                DATA_REQ: if (!busy) begin
                    din           <= 8'h40;
                    num_byte_send <= 5'd17;
                    newd          <= 1'b1;
                    byte_idx      <= 5'd0;
                    state         <= DATA_WAIT;
                end
                DATA_WAIT: begin
                    if (done) begin
                        if (ack_err) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else if (chunk != 3'd7) begin
                            chunk   <= chunk + 3'd1;
                            fb_addr <= {page, chunk + 3'd1, 4'd0};
                            state   <= DATA_REQ;
                        end else if (page != 3'd7) begin
                            page  <= page + 3'd1;
                            state <= PCMD_REQ;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end else if (dw_rise && byte_idx != 5'd16) begin
                        // fb_data answers the address issued on the previous step;
                        // the read for column 15 is the last one of the chunk.
                        byte_idx <= byte_idx + 5'd1;
                        din      <= fb_data;
                        if (byte_idx != 5'd15) fb_addr <= fb_addr + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Directed bench for oled_i2c_sequencer with a behavioural I2C master that
// captures every byte offered on din, plus a registered framebuffer model.
module tb_oled_i2c_sequencer;

    localparam int CLK_COUNT4 = 8;
    localparam int MAX_TX     = 80;
    localparam logic [7:0] INIT_EXP [26] = '{
        8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9,
        8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

    logic       clk, rst, start, refresh;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       newd, op;
    logic [6:0] waddr;
    logic [7:0] din;
    logic [4:0] num_byte_send;
    logic       busy, done, ack_err, done_write;
    logic       ready, inited, frame_done, err;

    int passed = 0;
    int total  = 0;
    int newd_count = 0, newd_cycles = 0, done_count = 0;
    int fd_count = 0, fd_last_done = 0, cur_bytes = 0;
    int cap_base = 0, nack_tx = -1;
    int m_idx, m_n;
    int         cap_len [MAX_TX];
    logic [7:0] cap     [MAX_TX][26];

    oled_i2c_sequencer #(.I2C_ADDR(7'h3C)) dut (
        .clk(clk), .rst(rst), .start(start), .refresh(refresh),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .newd(newd), .op(op), .waddr(waddr), .din(din), .num_byte_send(num_byte_send),
        .busy(busy), .done(done), .ack_err(ack_err), .done_write(done_write),
        .ready(ready), .inited(inited), .frame_done(frame_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fb_val(input logic [9:0] a);
        return a[7:0] ^ {5'b0, a[9:7]};
    endfunction

    always @(posedge clk) fb_data <= fb_val(fb_addr);

    always @(negedge clk) begin
        if (newd === 1'b1) newd_cycles <= newd_cycles + 1;
        if (frame_done === 1'b1) begin
            fd_count     <= fd_count + 1;
            fd_last_done <= done_count;
        end
    end

    // I2C master: byte 0 is taken with newd, later bytes 2 cycles after each done_write rise.
    initial begin
        busy = 1'b0; done = 1'b0; done_write = 1'b0; ack_err = 1'b0;
        forever begin
            @(negedge clk);
            if (newd === 1'b1) begin
                m_idx = newd_count - cap_base;
                m_n   = int'(num_byte_send);
                newd_count = newd_count + 1;
                if (m_idx >= 0 && m_idx < MAX_TX) begin
                    cap_len[m_idx] = m_n;
                    cap[m_idx][0]  = din;
                end
                busy = 1'b1;
                cur_bytes = 1;
                for (int i = 0; i < m_n; i++) begin
                    repeat (CLK_COUNT4) @(negedge clk);
                    done_write = 1'b1;
                    repeat (2) @(negedge clk);
                    if (i + 1 < m_n) begin
                        if (m_idx >= 0 && m_idx < MAX_TX && i + 1 < 26) cap[m_idx][i+1] = din;
                        cur_bytes = i + 2;
                    end
                    repeat (2) @(negedge clk);
                    done_write = 1'b0;
                end
                repeat (2) @(negedge clk);
                done = 1'b1; ack_err = (m_idx == nack_tx); busy = 1'b0;
                done_count = done_count + 1;
                @(negedge clk);
                done = 1'b0; ack_err = 1'b0;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; refresh = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({newd, frame_done, err, inited, ready, op} !== 6'b000010) begin
            $display("FAIL reset_ctrl: got %b want 000010", {newd, frame_done, err, inited, ready, op});
        end else passed++;
        total++;
        if ({din, num_byte_send, fb_addr} !== 23'd0) begin
            $display("FAIL reset_data: din=%h nbs=%0d fb_addr=%h want all 0", din, num_byte_send, fb_addr);
        end else passed++;
        total++;
        if (waddr !== 7'h3C) begin
            $display("FAIL reset_waddr: got %h want 3c", waddr);
        end else passed++;
    endtask

    task automatic test_refresh_before_init;
        int nbase;
        rst = 1'b0;
        @(negedge clk);
        nbase = newd_count;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (50) @(negedge clk);
        total++;
        if (newd_cycles !== 0 || newd_count - nbase !== 0) begin
            $display("FAIL refresh_before_init: newd cycles=%0d want 0", newd_cycles);
        end else passed++;
        total++;
        if (ready !== 1'b1 || inited !== 1'b0) begin
            $display("FAIL idle_after_refresh: ready=%b inited=%b want 1 0", ready, inited);
        end else passed++;
    endtask

    task automatic test_init_and_frame;
        int dbase, fbase, cbase;
        logic [7:0] pexp [4];
        pexp = '{8'h00, 8'hB0, 8'h00, 8'h10};
        cap_base = newd_count; dbase = done_count; fbase = fd_count; cbase = newd_cycles;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30000 && fd_count == fbase; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        total++;
        if (fd_count - fbase !== 1) begin
            $display("FAIL start_frame_done_count: got %0d want 1", fd_count - fbase);
        end else passed++;
        total++;
        if (fd_last_done - dbase !== 73) begin
            $display("FAIL start_frame_done_after: got done #%0d want 73", fd_last_done - dbase);
        end else passed++;
        total++;
        if (newd_count - cap_base !== 73 || newd_cycles - cbase !== 73) begin
            $display("FAIL start_newd_count: got %0d txn, %0d cycles want 73", newd_count - cap_base, newd_cycles - cbase);
        end else passed++;
        total++;
        if (cap_len[0] !== 26) begin
            $display("FAIL init_len: got %0d want 26", cap_len[0]);
        end else passed++;
        for (int i = 0; i < 26; i++) begin
            total++;
            if (cap[0][i] !== INIT_EXP[i]) begin
                $display("FAIL init_byte[%0d]: got %h want %h", i, cap[0][i], INIT_EXP[i]);
            end else passed++;
        end
        total++;
        if (inited !== 1'b1 || err !== 1'b0 || ready !== 1'b1) begin
            $display("FAIL after_frame_flags: inited=%b err=%b ready=%b want 1 0 1", inited, err, ready);
        end else passed++;
        total++;
        if (cap_len[1] !== 4 || cap_len[46] !== 4) begin
            $display("FAIL pcmd_len: page0=%0d page5=%0d want 4", cap_len[1], cap_len[46]);
        end else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cap[1][i] !== pexp[i]) begin
                $display("FAIL pcmd_page0[%0d]: got %h want %h", i, cap[1][i], pexp[i]);
            end else passed++;
            total++;
            if (cap[46][i] !== (i == 1 ? 8'hB5 : pexp[i])) begin
                $display("FAIL pcmd_page5[%0d]: got %h want %h", i, cap[46][i], (i == 1 ? 8'hB5 : pexp[i]));
            end else passed++;
        end
        // Transaction 23: init, 2 pages of 9, page-2 command, chunks 0..2, then chunk 3.
        total++;
        if (cap_len[23] !== 17 || cap[23][0] !== 8'h40) begin
            $display("FAIL data_p2c3_head: len=%0d byte0=%h want 17 40", cap_len[23], cap[23][0]);
        end else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap[23][i+1] !== fb_val(10'h130 + 10'(i))) begin
                $display("FAIL data_p2c3[%0d]: got %h want %h", i, cap[23][i+1], fb_val(10'h130 + 10'(i)));
            end else passed++;
        end
    endtask

    task automatic test_refresh_with_busy_guard;
        int dbase, fbase;
        cap_base = newd_count; dbase = done_count; fbase = fd_count;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        for (int c = 0; c < 5000 && newd_count - cap_base < 5; c++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        for (int c = 0; c < 30000 && fd_count == fbase; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        total++;
        if (newd_count - cap_base !== 72) begin
            $display("FAIL refresh_newd_count: got %0d want 72", newd_count - cap_base);
        end else passed++;
        total++;
        if (fd_count - fbase !== 1 || fd_last_done - dbase !== 72) begin
            $display("FAIL refresh_frame_done: count=%0d at done #%0d want 1 at 72", fd_count - fbase, fd_last_done - dbase);
        end else passed++;
        total++;
        if (cap_len[0] !== 4 || cap[0][1] !== 8'hB0 || inited !== 1'b1) begin
            $display("FAIL refresh_first_txn: len=%0d byte1=%h inited=%b want 4 b0 1", cap_len[0], cap[0][1], inited);
        end else passed++;
    endtask

    task automatic test_nack;
        int dbase, fbase;
        cap_base = newd_count; dbase = done_count; fbase = fd_count;
        nack_tx = 28;  // page 3 chunk 0 of a refresh frame
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        for (int c = 0; c < 15000 && done_count - dbase < 29; c++) @(negedge clk);
        repeat (100) @(negedge clk);
        total++;
        if (err !== 1'b1 || ready !== 1'b1) begin
            $display("FAIL nack_abort: err=%b ready=%b want 1 1", err, ready);
        end else passed++;
        total++;
        if (newd_count - cap_base !== 29 || fd_count - fbase !== 0) begin
            $display("FAIL nack_no_more: newd=%0d frame_done=%0d want 29 0", newd_count - cap_base, fd_count - fbase);
        end else passed++;
        nack_tx = -1;
        cap_base = newd_count;
        start = 1'b1; refresh = 1'b1;
        @(negedge clk);
        start = 1'b0; refresh = 1'b0;
        total++;
        if (err !== 1'b0 || inited !== 1'b0) begin
            $display("FAIL start_clears: err=%b inited=%b want 0 0", err, inited);
        end else passed++;
    endtask

    task automatic test_reset_during_data;
        int nbase;
        for (int c = 0; c < 5000 && !(newd_count - cap_base >= 4 && cur_bytes >= 5); c++) @(negedge clk);
        total++;
        if (cap_len[0] !== 26) begin
            $display("FAIL start_wins: first txn len=%0d want 26", cap_len[0]);
        end else passed++;
        total++;
        if (fb_addr !== 10'h014 || din !== fb_val(10'h013)) begin
            $display("FAIL pre_reset_data: fb_addr=%h din=%h want 014 %h", fb_addr, din, fb_val(10'h013));
        end else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({newd, frame_done, err, inited, ready, op} !== 6'b000010) begin
            $display("FAIL async_reset_ctrl: got %b want 000010", {newd, frame_done, err, inited, ready, op});
        end else passed++;
        total++;
        if ({din, num_byte_send, fb_addr} !== 23'd0) begin
            $display("FAIL async_reset_data: din=%h nbs=%0d fb_addr=%h want all 0", din, num_byte_send, fb_addr);
        end else passed++;
        nbase = newd_count;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
        repeat (50) @(negedge clk);
        total++;
        if (newd_count !== nbase || ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL post_reset_quiet: extra newd=%0d ready=%b busy=%b want 0 1 0", newd_count - nbase, ready, busy);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_refresh_before_init();
        test_init_and_frame();
        test_refresh_with_busy_guard();
        test_nack();
        test_reset_during_data();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
